// File: rtl/apb4_slave_regfile.sv
// APB4 completer fronting a bank of REG_NUM 32-bit read/write registers.
// Every access phase is stretched by WAIT_CYCLES pready-low cycles. Writes
// honour byte strobes. Out-of-range or misaligned addresses return pslverr.
// Register contents and one-cycle write pulses are exported to the owning IP.
module apb4_slave_regfile #(
  parameter int REG_NUM     = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [31:0]             pwdata,
  input  logic [3:0]              pstrb,
  output logic                    pready,
  output logic [31:0]             prdata,
  output logic                    pslverr,
  output logic [REG_NUM*32-1:0]   regs_o,
  output logic [REG_NUM-1:0]      wr_pulse_o
);

  localparam logic [8:0] REG_NUM_W = 9'(REG_NUM);
  localparam logic [3:0] WAIT_W    = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [31:0]          regs_q [REG_NUM];
  logic [31:0]          regs_d [REG_NUM];
  logic [REG_NUM-1:0]   wr_pulse_q, wr_pulse_d;

  logic [7:0]           idx_s;
  logic                 illegal_s;
  logic                 last_s;
  logic                 complete_s;
  logic                 wr_en_s;
  logic [31:0]          rd_mux_s;
  logic                 unused_s;

  // pprot and the address bits above the register index carry no meaning
  // here; upper address bits simply alias onto the same register bank.
  assign unused_s   = ^{pprot, paddr[ADDR_WIDTH-1:10]};

  assign idx_s      = paddr[9:2];
  assign illegal_s  = ({1'b0, idx_s} >= REG_NUM_W) || (paddr[1:0] != 2'b00);
  assign last_s     = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign complete_s = last_s && psel;
  assign wr_en_s    = complete_s && pwrite && !illegal_s;

  // Next-state logic: setup phase arms the access, wait counter stretches it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_W;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Register update and write pulse for a legal write at its completion edge.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (wr_en_s && (idx_s == 8'(i))) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (pstrb[b]) begin
            regs_d[i][8*b +: 8] = pwdata[8*b +: 8];
          end else begin
            regs_d[i][8*b +: 8] = regs_q[i][8*b +: 8];
          end
        end
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Read multiplexer over the register bank.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    for (int i = 0; i < REG_NUM; i++) begin
      if (idx_s == 8'(i)) begin
        rd_mux_s = regs_q[i];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
  end

  // Response drivers: only the final access cycle presents a response.
  always_comb begin
    pready  = 1'b0;
    prdata  = 32'h0000_0000;
    pslverr = 1'b0;
    if (last_s) begin
      pready  = 1'b1;
      pslverr = illegal_s;
      if (!illegal_s && !pwrite) begin
        prdata = rd_mux_s;
      end else begin
        prdata = 32'h0000_0000;
      end
    end else begin
      pready = 1'b0;
    end
  end

  // State, counter, register bank and pulse flops; reset discards any access.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      wr_pulse_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign wr_pulse_o = wr_pulse_q;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_regs_out
    assign regs_o[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_apb4_slave_regfile.sv
// Bench for apb4_slave_regfile: one instance with no wait states and one with
// three, sharing the bus except for psel. Expected values come from a
// register-array model updated with byte-mask arithmetic.
module tb_apb4_slave_regfile;

  logic         pclk;
  logic         presetn;
  logic [31:0]  paddr;
  logic [2:0]   pprot;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  int           tgt;

  logic         psel0, psel1;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [31:0]  prdata0, prdata1;
  logic [255:0] regs0, regs1;
  logic [7:0]   pulse0, pulse1;

  logic         pready_t, pslverr_t;
  logic [31:0]  prdata_t;
  logic [255:0] regs_t;
  logic [7:0]   pulse_t;

  int           n_total = 0;
  int           n_bad   = 0;
  logic [31:0]  model [2][8];

  assign psel0     = psel && (tgt == 0);
  assign psel1     = psel && (tgt == 1);
  assign pready_t  = (tgt == 1) ? pready1  : pready0;
  assign pslverr_t = (tgt == 1) ? pslverr1 : pslverr0;
  assign prdata_t  = (tgt == 1) ? prdata1  : prdata0;
  assign regs_t    = (tgt == 1) ? regs1    : regs0;
  assign pulse_t   = (tgt == 1) ? pulse1   : pulse0;

  apb4_slave_regfile #(.REG_NUM(8), .WAIT_CYCLES(0), .ADDR_WIDTH(32)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot),
    .psel(psel0), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .regs_o(regs0), .wr_pulse_o(pulse0)
  );

  apb4_slave_regfile #(.REG_NUM(8), .WAIT_CYCLES(3), .ADDR_WIDTH(32)) u_dut3 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot),
    .psel(psel1), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready1), .prdata(prdata1), .pslverr(pslverr1),
    .regs_o(regs1), .wr_pulse_o(pulse1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic bit addr_err(input logic [31:0] a);
    return ((a % 4) != 0) || (((a / 4) % 256) >= 8);
  endfunction

  task automatic zero_model();
    for (int t = 0; t < 2; t++) for (int r = 0; r < 8; r++) model[t][r] = 32'h0;
  endtask

  // One complete transfer; returns response, access-cycle count and the pulse
  // vector seen in the cycle after completion.
  task automatic apb_xfer(input int t, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er,
                          output int cyc, output logic [7:0] pl);
    bit done;
    tgt = t;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    pprot = 3'($urandom_range(0, 7));
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 0; rd = 32'h0; er = 1'b0; done = 1'b0;
    while (!done && cyc < 20) begin
      cyc++;
      @(negedge pclk);
      if (pready_t) begin
        rd = prdata_t; er = pslverr_t; done = 1'b1;
      end
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    pl = pulse_t;
    if (!done) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input int t, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd, exp_rd;
    logic        er;
    logic [7:0]  pl, exp_pl;
    int          cyc, idx;
    bit          bad;
    bad = addr_err(a);
    idx = int'((a / 4) % 256);
    exp_rd = 32'h0;
    exp_pl = 8'h0;
    if (!bad && !wr) exp_rd = model[t][idx];
    if (!bad && wr) exp_pl = 8'(1 << idx);
    apb_xfer(t, wr, a, d, s, rd, er, cyc, pl);
    chk("pslverr", 64'(er), 64'(bad));
    if (!wr) chk("prdata", 64'(rd), 64'(exp_rd));
    chk("cycles", 64'(cyc), (t == 1) ? 64'd4 : 64'd1);
    chk("wr_pulse", 64'(pl), 64'(exp_pl));
    if (!bad && wr) model[t][idx] = merge(model[t][idx], d, s);
    for (int r = 0; r < 8; r++) chk("regs_o", 64'(regs_t[32*r +: 32]), 64'(model[t][r]));
    @(posedge pclk); #1;
    chk("pulse_end", 64'(pulse_t), 64'd0);
  endtask

  initial begin
    presetn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'h0; tgt = 0;
    zero_model();
    #2 presetn = 1'b0;
    #1;
    chk("rst_pready", 64'({pready0, pready1}), 64'd0);
    chk("rst_prdata", 64'(prdata0 | prdata1), 64'd0);
    chk("rst_pslverr", 64'({pslverr0, pslverr1}), 64'd0);
    chk("rst_pulse", 64'({pulse0, pulse1}), 64'd0);
    chk("rst_regs", 64'(|{regs0, regs1}), 64'd0);
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;

    // Every register reads zero after reset, on both instances.
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 8; r++) run(t, 1'b0, 32'(4 * r), 32'h0, 4'h0);

    // Full-word write and read-back, no wait states.
    run(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF);
    chk("deadbeef_regs_o", 64'(regs0[63:32]), 64'hDEAD_BEEF);
    run(0, 1'b0, 32'h04, 32'h0, 4'h0);

    // Byte strobes.
    run(0, 1'b1, 32'h08, 32'h1122_3344, 4'hF);
    run(0, 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101);
    chk("strb_regs_o", 64'(regs0[95:64]), 64'h11BB_33DD);
    run(0, 1'b0, 32'h08, 32'h0, 4'h0);
    run(0, 1'b1, 32'h10, 32'h5555_5555, 4'h0);

    // Wait states, error responses.
    run(1, 1'b0, 32'h00, 32'h0, 4'h0);
    run(0, 1'b0, 32'h20, 32'h0, 4'h0);
    run(0, 1'b1, 32'h06, 32'h1234_5678, 4'hF);
    run(1, 1'b1, 32'h21, 32'h1234_5678, 4'hF);

    // Access phase without a setup phase is ignored.
    tgt = 0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    repeat (3) begin
      @(negedge pclk);
      chk("no_setup_pready", 64'(pready0), 64'd0);
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    chk("no_setup_reg0", 64'(regs0[31:0]), 64'(model[0][0]));
    chk("no_setup_pulse", 64'(pulse0), 64'd0);

    // Abort: psel dropped after one wait cycle.
    tgt = 1;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready", 64'(pready1), 64'd0);
    @(posedge pclk); #1;
    chk("abort_pulse", 64'(pulse1), 64'd0);
    chk("abort_reg3", 64'(regs1[127:96]), 64'(model[1][3]));
    run(1, 1'b0, 32'h0C, 32'h0, 4'h0);

    // Reset during the ready cycle of a write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (3) begin @(posedge pclk); #1; end
    @(negedge pclk);
    chk("pre_rst_pready", 64'(pready1), 64'd1);
    #1 presetn = 1'b0;
    #1;
    chk("mid_rst_pready", 64'(pready1), 64'd0);
    chk("mid_rst_reg3", 64'(regs1[127:96]), 64'd0);
    zero_model();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 presetn = 1'b1;
    @(posedge pclk); #1;
    chk("post_rst_pulse", 64'(pulse1), 64'd0);
    chk("post_rst_reg3", 64'(regs1[127:96]), 64'd0);
    run(1, 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF);
    run(1, 1'b0, 32'h0C, 32'h0, 4'h0);

    // Randomized traffic with aliasing and misalignment.
    for (int n = 0; n < 120; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 47));
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
          4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
